stack_param: RTL

// - Parametrised LIFO stack; next generation of the fixed 8x16 stack used by the datapath.
// - Generalises width and depth. Adds:
//   - registered pop data with a valid strobe;
//   - a combinational top-of-stack peek;
//   - an occupancy count and a programmable almost-full flag;
//   - simultaneous push+pop (replace top);
//   - sticky overflow/underflow error flags.
// - Sits between the operand/return-address producer and its consumer.

---
 rtl/stack_pkg.sv | 13 +
 rtl/stack_mem.sv | 29 ++
 rtl/stack_param.sv | 123 ++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared helpers for the parametrised LIFO stack: count width and op encoding.
package stack_pkg;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_PUSH = 2'd2;
  localparam logic [1:0] OP_REPL = 2'd3;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, two asynchronous read ports.
module stack_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_pop,
  output logic [WIDTH-1:0] rd_data_pop,
  input  logic [AW-1:0]    rd_addr_peek,
  output logic [WIDTH-1:0] rd_data_peek
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally never reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_pop  = mem[rd_addr_pop];
  assign rd_data_peek = mem[rd_addr_peek];

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack with registered pop data, peek, occupancy flags,
// replace-top on simultaneous push+pop, and sticky overflow/underflow flags.
module stack_param
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  input  logic [WIDTH-1:0]             value_in,
  output logic [WIDTH-1:0]             value_out,
  output logic                         pop_valid,
  output logic [WIDTH-1:0]             top_value,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_c;
  logic [WIDTH-1:0] value_out_c;
  logic             pop_valid_c, overflow_c, underflow_c;
  logic             wr_en_c;
  logic [AW-1:0]    wr_addr_c, top_addr_c, sp_addr_c;
  logic [WIDTH-1:0] rd_pop_c, rd_peek_c;
  logic [1:0]       op_c;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign count       = count_q;

  // sp addresses the next free slot; top is sp-1 (held at 0 when empty).
  assign sp_addr_c  = AW'(count_q);
  assign top_addr_c = empty ? '0 : AW'(count_q - CNT_W'(1));
  assign op_c       = {push, pop};

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk          (clk),
    .wr_en        (wr_en_c & reset),
    .wr_addr      (wr_addr_c),
    .wr_data      (value_in),
    .rd_addr_pop  (top_addr_c),
    .rd_data_pop  (rd_pop_c),
    .rd_addr_peek (top_addr_c),
    .rd_data_peek (rd_peek_c)
  );

  assign top_value = empty ? '0 : rd_peek_c;

  // Op decode; a same-cycle set event overrides err_clr on the sticky flags.
  always_comb begin
    count_c     = count_q;
    value_out_c = value_out;
    pop_valid_c = 1'b0;
    overflow_c  = overflow & ~err_clr;
    underflow_c = underflow & ~err_clr;
    wr_en_c     = 1'b0;
    wr_addr_c   = sp_addr_c;
    case (op_c)
      OP_PUSH: begin
        if (!full) begin
          wr_en_c = 1'b1;
          count_c = count_q + CNT_W'(1);
        end else begin
          overflow_c = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          value_out_c = rd_pop_c;
          pop_valid_c = 1'b1;
          count_c     = count_q - CNT_W'(1);
        end else begin
          underflow_c = 1'b1;
        end
      end
      OP_REPL: begin
        wr_en_c = 1'b1;
        if (!empty) begin
          value_out_c = rd_pop_c;
          pop_valid_c = 1'b1;
          wr_addr_c   = top_addr_c;
        end else begin
          wr_addr_c   = '0;
          count_c     = CNT_W'(1);
          underflow_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      value_out <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count_q   <= count_c;
      value_out <= value_out_c;
      pop_valid <= pop_valid_c;
      overflow  <= overflow_c;
      underflow <= underflow_c;
    end
  end

endmodule
